// File: rtl/dcache_controller.sv
// dcache_controller: 2-way, 16-set, 32-byte-line write-back cache sequencer
// with per-set LRU, store merging, and memory write-back/refill handshakes.
module dcache_controller (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         cpu_req_i,
  input  logic         cpu_write_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [3:0]   sram_addr_o,
  output logic         sram_way_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  input  logic [24:0]  sram_tag0_i,
  input  logic [24:0]  sram_tag1_i,
  input  logic [255:0] sram_data0_i,
  input  logic [255:0] sram_data1_i,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
);
  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;
  state_t state;
  logic [15:0] lru;
  logic victim;
  logic [31:5] req_line;
  logic [255:0] refill_buf, hit_line, vic_line, merged;
  logic [24:0] vic_tag;
  logic [3:0] idx;
  logic [7:0] bit_off;
  logic idle, refill, wb, alloc, hit0, hit1, hit, hit_way, wr_hit, vsel, unused_ok;
  assign idle = state == IDLE;
  assign refill = state == REFILL;
  assign wb = state == WRITEBACK;
  assign alloc = state == ALLOCATE;
  assign idx = cpu_addr_i[8:5];
  assign bit_off = {cpu_addr_i[4:2], 5'd0};
  assign unused_ok = ^cpu_addr_i[1:0];
  assign hit0 = sram_tag0_i[24] & (sram_tag0_i[22:0] == cpu_addr_i[31:9]);
  assign hit1 = sram_tag1_i[24] & (sram_tag1_i[22:0] == cpu_addr_i[31:9]);
  assign hit = idle & cpu_req_i & (hit0 | hit1);
  assign hit_way = ~hit0;
  assign wr_hit = hit & cpu_write_i;
  assign hit_line = hit_way ? sram_data1_i : sram_data0_i;
  // In IDLE the victim is the candidate for a miss; afterwards it is the latched one.
  assign vsel = idle ? lru[idx] : victim;
  assign vic_tag = vsel ? sram_tag1_i : sram_tag0_i;
  assign vic_line = vsel ? sram_data1_i : sram_data0_i;
  always_comb begin
    merged = hit_line;
    merged[bit_off +: 32] = cpu_data_i;
  end
  assign cpu_data_o = hit ? hit_line[bit_off +: 32] : 32'd0;
  assign cpu_stall_o = ~idle | (cpu_req_i & ~hit);
  assign sram_addr_o = idle ? (cpu_req_i ? idx : 4'd0) : req_line[8:5];
  assign sram_enable_o = ~idle | cpu_req_i;
  assign sram_write_o = wr_hit | refill;
  assign sram_way_o = refill ? victim : wr_hit & hit_way;
  assign sram_tag_o = refill ? {2'b10, req_line[31:9]} : wr_hit ? {2'b11, cpu_addr_i[31:9]} : 25'd0;
  assign sram_data_o = refill ? refill_buf : wr_hit ? merged : 256'd0;
  assign mem_enable_o = wb | alloc;
  assign mem_write_o = wb;
  assign mem_addr_o = wb ? {vic_tag[22:0], req_line[8:5], 5'd0} : alloc ? {req_line, 5'd0} : 32'd0;
  assign mem_data_o = wb ? vic_line : 256'd0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      lru <= '0;
      victim <= 1'b0;
      req_line <= '0;
      refill_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            lru[idx] <= ~hit_way;
          end else if (cpu_req_i) begin
            victim <= vsel;
            req_line <= cpu_addr_i[31:5];
            state <= (vic_tag[24] & vic_tag[23]) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: if (mem_ack_i) state <= ALLOCATE;
        ALLOCATE: begin
          if (mem_ack_i) begin
            refill_buf <= mem_data_i;
            state <= REFILL;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_controller.sv
// tb_dcache_controller: table-driven bench with SRAM/memory models and
// scoreboards for load data and memory transactions.
module tb_dcache_controller;
  logic clk_i = 1'b0;
  logic rst_i, cpu_req_i, cpu_write_i;
  logic [31:0] cpu_addr_i, cpu_data_i, cpu_data_o;
  logic cpu_stall_o;
  logic [3:0] sram_addr_o;
  logic sram_way_o, sram_enable_o, sram_write_o;
  logic [24:0] sram_tag_o, sram_tag0_i, sram_tag1_i;
  logic [255:0] sram_data_o, sram_data0_i, sram_data1_i;
  logic mem_enable_o, mem_write_o, mem_ack_i;
  logic [31:0] mem_addr_o;
  logic [255:0] mem_data_o, mem_data_i;
  int tests = 0;
  int fails = 0;
  always #5 clk_i = ~clk_i;
  dcache_controller dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i),
    .cpu_addr_i(cpu_addr_i), .cpu_data_i(cpu_data_i),
    .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_addr_o(sram_addr_o), .sram_way_o(sram_way_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o),
    .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o),
    .sram_tag0_i(sram_tag0_i), .sram_tag1_i(sram_tag1_i),
    .sram_data0_i(sram_data0_i), .sram_data1_i(sram_data1_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );
  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // SRAM model: combinational read, write on clock edge
  logic clr;
  logic [24:0] tag_m [2][16];
  logic [255:0] dat_m [2][16];
  int sram_wr_cnt;
  assign sram_tag0_i = tag_m[0][sram_addr_o];
  assign sram_tag1_i = tag_m[1][sram_addr_o];
  assign sram_data0_i = dat_m[0][sram_addr_o];
  assign sram_data1_i = dat_m[1][sram_addr_o];
  always @(posedge clk_i) begin
    if (clr) begin
      for (int w = 0; w < 2; w++)
        for (int s = 0; s < 16; s++) begin
          tag_m[w][s] <= '0;
          dat_m[w][s] <= '0;
        end
      sram_wr_cnt <= 0;
    end else if (sram_enable_o && sram_write_o) begin
      tag_m[sram_way_o][sram_addr_o] <= sram_tag_o;
      dat_m[sram_way_o][sram_addr_o] <= sram_data_o;
      sram_wr_cnt <= sram_wr_cnt + 1;
    end
  end
  // Reference memory contents and store history
  logic [255:0] mem_m [logic [31:0]];
  logic [31:0] ref_st [logic [31:0]];
  function automatic logic [31:0] pat_word(input logic [31:0] a);
    return (a == 32'h120) ? 32'hDEADBEEF : a ^ 32'h5A5A0000;
  endfunction
  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (mem_m.exists(la)) return mem_m[la];
    for (int i = 0; i < 8; i++) l[32*i +: 32] = pat_word(la + 32'(4 * i));
    return l;
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_st.exists(a) ? ref_st[a] : pat_word(a);
  endfunction
  function automatic logic [255:0] ref_line(input logic [31:0] la);
    logic [255:0] l;
    for (int i = 0; i < 8; i++) l[32*i +: 32] = ref_rd(la + 32'(4 * i));
    return l;
  endfunction
  typedef struct packed {logic wr; logic [31:0] addr; logic [255:0] data;} mtx_t;
  mtx_t exp_mem[$];
  logic [31:0] exp_q[$];
  int lat = 5;
  int mcnt;
  task automatic mem_xfer;
    mtx_t e;
    if (exp_mem.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL mem_unexpected: got write=%b addr=%h, expected no transfer", mem_write_o, mem_addr_o);
    end else begin
      e = exp_mem.pop_front();
      chk("mem_write", 256'(mem_write_o), 256'(e.wr));
      chk("mem_addr", 256'(mem_addr_o), 256'(e.addr));
      if (e.wr) chk("wb_line", mem_data_o, e.data);
    end
    if (mem_write_o) mem_m[mem_addr_o] = mem_data_o;
    else mem_data_i = mem_line(mem_addr_o);
  endtask
  always @(negedge clk_i) begin
    if (rst_i || !mem_enable_o) begin
      mcnt = 0;
      mem_ack_i = 1'b0;
    end else begin
      if (mem_ack_i) mcnt = 0;
      mcnt++;
      mem_ack_i = (mcnt == lat);
      if (mem_ack_i) mem_xfer();
    end
  end
  typedef struct {logic [31:0] addr; logic wr; logic [31:0] data; int stall; logic [31:0] wb;} vec_t;
  task automatic run_vec(input vec_t v);
    int cyc;
    logic [31:0] e;
    cyc = 0;
    if (v.stall > 0) begin
      if (v.wb != 0) exp_mem.push_back('{1'b1, v.wb, ref_line(v.wb)});
      exp_mem.push_back('{1'b0, {v.addr[31:5], 5'd0}, 256'd0});
    end
    if (!v.wr) exp_q.push_back(ref_rd(v.addr));
    else ref_st[v.addr] = v.data;
    cpu_req_i = 1'b1;
    cpu_write_i = v.wr;
    cpu_addr_i = v.addr;
    cpu_data_i = v.data;
    #1;
    while (cpu_stall_o && cyc < 100) begin
      @(negedge clk_i);
      #1;
      cyc++;
    end
    chk("stall_cycles", 256'(cyc), 256'(v.stall));
    if (!v.wr) begin
      e = exp_q.pop_front();
      chk("load_data", 256'(cpu_data_o), 256'(e));
    end
    @(negedge clk_i);
    cpu_req_i = 1'b0;
  endtask
  task automatic do_reset;
    rst_i = 1'b1;
    clr = 1'b1;
    cpu_req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    clr = 1'b0;
  endtask
  initial begin
    vec_t t1[4];
    vec_t lru_t[4];
    vec_t b2b[10];
    int w;
    t1[0] = '{32'h120, 1'b0, 32'd0, 7, 32'd0};
    t1[1] = '{32'h124, 1'b1, 32'h12345678, 0, 32'd0};
    t1[2] = '{32'h320, 1'b0, 32'd0, 7, 32'd0};
    t1[3] = '{32'h520, 1'b0, 32'd0, 12, 32'h120};
    lru_t[0] = '{32'h120, 1'b0, 32'd0, 7, 32'd0};
    lru_t[1] = '{32'h320, 1'b0, 32'd0, 7, 32'd0};
    lru_t[2] = '{32'h120, 1'b0, 32'd0, 0, 32'd0};
    lru_t[3] = '{32'h520, 1'b0, 32'd0, 7, 32'd0};
    for (int i = 0; i < 10; i++)
      b2b[i] = '{(i % 2 == 0) ? 32'h120 + 32'(4 * (i / 2)) : 32'h700 + 32'(4 * (i / 2)), 1'b0, 32'd0, 0, 32'd0};
    cpu_write_i = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    do_reset();
    #1;
    chk("rst_stall", 256'(cpu_stall_o), 256'(0));
    chk("rst_cpu_data", 256'(cpu_data_o), 256'(0));
    chk("rst_sram_en", 256'({sram_enable_o, sram_write_o, sram_way_o}), 256'(0));
    chk("rst_sram_addr", 256'(sram_addr_o), 256'(0));
    chk("rst_sram_tag", 256'(sram_tag_o), 256'(0));
    chk("rst_mem", 256'({mem_enable_o, mem_write_o, mem_addr_o}), 256'(0));
    @(negedge clk_i);
    for (int i = 0; i < 4; i++) begin
      w = sram_wr_cnt;
      run_vec(t1[i]);
      if (i == 0) chk("cold_tag", 256'(tag_m[0][9]), 256'(25'h1000000));
      if (i == 1) begin
        chk("wr_hit_writes", 256'(sram_wr_cnt - w), 256'(1));
        chk("wr_hit_tag", 256'(tag_m[0][9]), 256'(25'h1800000));
        chk("wr_hit_word", 256'(dat_m[0][9][63:32]), 256'(32'h12345678));
        chk("wr_hit_word0", 256'(dat_m[0][9][31:0]), 256'(32'hDEADBEEF));
      end
      if (i == 3) chk("evict_tag", 256'(tag_m[0][9]), 256'({2'b10, 23'd2}));
    end
    do_reset();
    for (int i = 0; i < 4; i++) run_vec(lru_t[i]);
    chk("lru_way1_tag", 256'(tag_m[1][9]), 256'({2'b10, 23'd2}));
    chk("lru_way0_tag", 256'(tag_m[0][9]), 256'({2'b10, 23'd0}));
    cpu_req_i = 1'b1;
    cpu_write_i = 1'b0;
    cpu_addr_i = 32'h700;
    #1;
    chk("abort_miss_stall", 256'(cpu_stall_o), 256'(1));
    repeat (3) @(negedge clk_i);
    #1;
    chk("abort_mem_en", 256'({mem_enable_o, mem_write_o}), 256'(2'b10));
    chk("abort_mem_addr", 256'(mem_addr_o), 256'(32'h700));
    w = sram_wr_cnt;
    rst_i = 1'b1;
    cpu_req_i = 1'b0;
    @(negedge clk_i);
    #1;
    chk("abort_mem_off", 256'(mem_enable_o), 256'(0));
    chk("abort_stall_off", 256'(cpu_stall_o), 256'(0));
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("abort_no_sram_wr", 256'(sram_wr_cnt - w), 256'(0));
    run_vec('{32'h700, 1'b0, 32'd0, 7, 32'd0});
    for (int i = 0; i < 10; i++) run_vec(b2b[i]);
    chk("mem_pending", 256'(exp_mem.size()), 256'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
